// File: rtl/cp0_reg_pkg.sv
// rtl/cp0_reg_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_RI        = 32'h0000_000a;
    localparam logic [31:0] EXC_OV        = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    localparam int STATUS_EXL   = 1;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IV     = 23;
    localparam int CAUSE_WP     = 22;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_SW_HI  = 9;
    localparam int CAUSE_SW_LO  = 8;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    // Returns {handled, ExcCode}; eret and unknown codes come back unhandled.
    function automatic logic [5:0] exc_decode(input logic [31:0] excepttype);
        logic [5:0] r;
        r = 6'd0;
        case (excepttype)
            EXC_INTERRUPT: r = {1'b1, 5'd0};
            EXC_SYSCALL:   r = {1'b1, 5'd8};
            EXC_RI:        r = {1'b1, 5'd10};
            EXC_OV:        r = {1'b1, 5'd12};
            EXC_TRAP:      r = {1'b1, 5'd13};
            default:       r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - CP0 register bank with Count/Compare timer and exception bookkeeping
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
    parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] count_n, compare_n, status_n, cause_n, epc_n;
    logic        timer_n;
    logic [5:0]  exc;

    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;
    assign exc      = exc_decode(excepttype_i);

    always_comb begin
        count_n   = count_o + 32'd1;
        compare_n = compare_o;
        status_n  = status_o;
        cause_n   = cause_o;
        epc_n     = epc_o;
        timer_n   = timer_int_o;

        if (compare_o != 32'd0 && count_o == compare_o)
            timer_n = 1'b1;
        cause_n[CAUSE_IP_HI:CAUSE_IP_LO] = int_i;

        if (we_i) begin
            case (waddr_i)
                CP0_REG_COUNT:   count_n = wdata_i;
                CP0_REG_COMPARE: begin
                    compare_n = wdata_i;
                    timer_n   = 1'b0;
                end
                CP0_REG_STATUS:  status_n = wdata_i;
                CP0_REG_CAUSE:   begin
                    cause_n[CAUSE_SW_HI:CAUSE_SW_LO] = wdata_i[CAUSE_SW_HI:CAUSE_SW_LO];
                    cause_n[CAUSE_WP] = wdata_i[CAUSE_WP];
                    cause_n[CAUSE_IV] = wdata_i[CAUSE_IV];
                end
                CP0_REG_EPC:     epc_n = wdata_i;
                default: ;
            endcase
        end

        // Exception state lands on top of any same-edge software write.
        if (exc[5]) begin
            if (!status_n[STATUS_EXL]) begin
                epc_n = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                cause_n[CAUSE_BD] = is_in_delayslot_i;
            end
            status_n[STATUS_EXL] = 1'b1;
            cause_n[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc[4:0];
        end else if (excepttype_i == EXC_ERET) begin
            status_n[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= 32'd0;
            compare_o   <= 32'd0;
            status_o    <= STATUS_RESET;
            cause_o     <= 32'd0;
            epc_o       <= 32'd0;
            timer_int_o <= 1'b0;
        end else begin
            count_o     <= count_n;
            compare_o   <= compare_n;
            status_o    <= status_n;
            cause_o     <= cause_n;
            epc_o       <= epc_n;
            timer_int_o <= timer_n;
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = count_o;
            CP0_REG_COMPARE: data_o = compare_o;
            CP0_REG_STATUS:  data_o = status_o;
            CP0_REG_CAUSE:   data_o = cause_o;
            CP0_REG_EPC:     data_o = epc_o;
            CP0_REG_PRID:    data_o = PRID_VALUE;
            CP0_REG_CONFIG:  data_o = CONFIG_VALUE;
            default:         data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// tb/tb_cp0_reg.sv - directed self-checking bench for cp0_reg
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int tests_run = 0;
    int tests_failed = 0;

    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_write(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = 5'd12;
        int_i = '0; excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
        tick(); tick();

        check("rst_count", count_o, 32'd0);
        check("rst_compare", compare_o, 32'd0);
        check("rst_status", status_o, 32'h1000_0000);
        check("rst_status_rd", data_o, 32'h1000_0000);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_config", config_o, 32'h0000_8000);
        check("rst_prid", prid_o, 32'h004C_0102);
        check("rst_timer", {31'd0, timer_int_o}, 32'd0);

        rst = 1'b0; raddr_i = 5'd9;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("count_inc%0d", i), data_o, i);
        end

        // Timer: count=10, then compare=20 (count becomes 11)
        sw_write(5'd9, 32'd10);
        check("count_wr10", count_o, 32'd10);
        sw_write(5'd11, 32'd20);
        check("compare_wr", compare_o, 32'd20);
        check("count_11", count_o, 32'd11);
        for (int i = 0; i < 9; i++) tick();
        check("count_20", count_o, 32'd20);
        check("timer_pre", {31'd0, timer_int_o}, 32'd0);
        tick();
        check("timer_rise", {31'd0, timer_int_o}, 32'd1);
        tick(); tick();
        check("timer_sticky", {31'd0, timer_int_o}, 32'd1);
        sw_write(5'd11, 32'd100);
        check("timer_clear", {31'd0, timer_int_o}, 32'd0);
        raddr_i = 5'd11;
        #1 check("compare_rd", data_o, 32'd100);

        // Count wrap and write-wins
        raddr_i = 5'd9;
        sw_write(5'd9, 32'hFFFF_FFFE);
        check("count_wr_wins", count_o, 32'hFFFF_FFFE);
        tick();
        check("count_ffff", count_o, 32'hFFFF_FFFF);
        tick();
        check("count_wrap", count_o, 32'd0);

        // Syscall in delay slot with EXL=0
        excepttype_i = 32'h8; current_inst_addr_i = 32'h100; is_in_delayslot_i = 1'b1;
        tick();
        check("sys_epc", epc_o, 32'h0000_00FC);
        check("sys_cause", cause_o, 32'h8000_0020);
        check("sys_status", status_o, 32'h1000_0002);
        // Trap with EXL=1: EPC/BD held, ExcCode updated
        excepttype_i = 32'hd; current_inst_addr_i = 32'h200; is_in_delayslot_i = 1'b0;
        tick();
        check("exl_epc_hold", epc_o, 32'h0000_00FC);
        check("exl_cause", cause_o, 32'h8000_0034);

        // Unknown nonzero code: no change
        excepttype_i = 32'h5;
        tick();
        check("unk_status", status_o, 32'h1000_0002);
        check("unk_cause", cause_o, 32'h8000_0034);

        // eret
        excepttype_i = 32'he;
        tick();
        check("eret_status", status_o, 32'h1000_0000);
        check("eret_epc", epc_o, 32'h0000_00FC);
        excepttype_i = 32'h0; int_i = 6'b100001;
        tick();
        check("ip_sample", cause_o, 32'h8000_8434);

        // Same-edge Status write + RI exception
        excepttype_i = 32'ha; current_inst_addr_i = 32'h300;
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1000_0000;
        tick();
        we_i = 1'b0; excepttype_i = 32'h0;
        check("ri_status", status_o, 32'h1000_0002);
        check("ri_cause", cause_o, 32'h0000_8428);
        check("ri_epc", epc_o, 32'h0000_0300);

        // Cause write mask
        sw_write(5'd13, 32'hFFFF_FFFF);
        check("cause_mask", cause_o, 32'h00C0_8728);

        // Read-only registers and unmapped reads
        sw_write(5'd15, 32'hFFFF_FFFF);
        sw_write(5'd16, 32'hFFFF_FFFF);
        raddr_i = 5'd15;
        #1 check("prid_rd", data_o, 32'h004C_0102);
        raddr_i = 5'd16;
        #1 check("config_rd", data_o, 32'h0000_8000);
        raddr_i = 5'd3;
        #1 check("unmapped_rd", data_o, 32'd0);
        sw_write(5'd14, 32'hDEAD_BEEF);
        raddr_i = 5'd14;
        #1 check("epc_sw", data_o, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- System-control coprocessor register bank; the consumer end of the write-back CP0 write channel.
- Write-back stage drives we/waddr/wdata.
- Also provides:
  - the free-running Count/Compare timer and its interrupt
  - hardware-interrupt sampling into Cause
  - exception/ERET bookkeeping (EPC, Status.EXL, Cause.BD/ExcCode) on requests from the memory stage
- Read port feeds the execute stage (mfc0); the execute stage performs its own bypass from MEM/WB.

Parameters:
PRID_VALUE, 32'h004C0102, read-only processor ID.
CONFIG_VALUE, 32'h00008000, read-only Config (BE=1).
STATUS_RESET, 32'h10000000, Status reset value (CU0=1).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
we_i  input  1  CP0 write enable from write-back
waddr_i  input  5  CP0 register number to write
wdata_i  input  32  write data
raddr_i  input  5  CP0 register number to read
int_i  input  6  external hardware interrupt lines
excepttype_i  input  32  exception request, 0 = none
current_inst_addr_i  input  32  PC of the excepting instruction
is_in_delayslot_i  input  1  excepting instruction is in a delay slot
data_o  output  32  read data
count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  output  32 each  direct register views
timer_int_o  output  1  timer interrupt, level, sticky

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - count=0, compare=0, status=STATUS_RESET, cause=0, epc=0
  - config=CONFIG_VALUE, prid=PRID_VALUE, timer_int_o=0
  - reset overrides all other inputs in the same cycle.
- Register numbers: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
- data_o: combinational on raddr_i; unmapped numbers read 0; no internal write-to-read bypass.
- Count:
  - increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
  - a software write in the same cycle wins: count <= wdata_i, no increment that cycle.
- Timer:
  - compare != 0 and count == compare: timer_int_o <= 1 on the next edge.
  - stays 1 until a software write to Compare, which loads compare and clears timer_int_o in the same edge.
  - if a Compare write coincides with a match, the clear wins.
- Cause IP[15:10] <= int_i every cycle; software cannot write them.
- Software writes per register:
  - Status: full 32 bits.
  - EPC: full 32 bits.
  - Cause: only IP[9:8], WP[22], IV[23] are writable; other bits are preserved.
  - PRId, Config: writes ignored.
- Exception update (excepttype_i != 0):
  - Applied after the software write of the same edge; overlapping fields take the exception value.
  - Codes handled:
    - 0x1 interrupt -> ExcCode 0
    - 0x8 syscall -> ExcCode 8
    - 0xa reserved instruction -> ExcCode 10
    - 0xc overflow -> ExcCode 12
    - 0xd trap -> ExcCode 13
  - For a handled code:
    - if Status.EXL==0: epc <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i, and Cause.BD <= is_in_delayslot_i.
    - if Status.EXL==1: epc and BD are unchanged.
    - Always: Status.EXL <= 1; Cause.ExcCode[6:2] <= code.
  - 0xe (eret): Status.EXL <= 0 only.
  - Any other nonzero value: no architectural change.
- The exception path never touches count or compare.

Decomposition:
- Shared defines header gets:
  - CP0 register number constants (CP0_REG_COUNT ... CP0_REG_CONFIG)
  - exception type codes
  - Status/Cause bit-position constants
- Single flat module; no sub-module warranted.

Test Plan:
1. Release rst -> status=32'h10000000, config=32'h00008000, prid=32'h004C0102, cause=0; count reads 1,2,3 on successive cycles.
2. Write compare=20 while count=10 -> timer_int_o rises one edge after count==20 and stays high; write compare=100 -> timer_int_o=0 next edge.
3. Write count=32'hFFFFFFFE -> next reads 32'hFFFFFFFF, then 0 (wrap); write count in a cycle -> that value, not value+1.
4. Syscall exception with excepttype=8, PC=32'h100, delayslot=1, EXL=0 -> epc=32'h0FC, Cause.BD=1, ExcCode=8, EXL=1; a second exception at PC=32'h200 -> epc stays 32'h0FC, ExcCode updated.
5. eret (0xe) -> EXL=0 with EPC unchanged; int_i=6'b100001 -> cause[15:10]=6'b100001 next edge.
6. Same edge: software Status write with EXL=0 plus exception 0xa -> EXL=1, ExcCode=10; Cause write of 32'hFFFFFFFF -> only bits 23,22,9,8 set, ExcCode/IP[15:10]/BD unaffected.
